dmem_sized_hs: RTL



---
 rtl/dmem_sized_hs.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_sized_hs.sv
// dmem_sized_hs: byte-addressed RV32 data memory with a req/resp handshake.
// The memory supports B/H/W loads (sign or zero extended) and stores with
// per-byte lane enables. A configurable number of wait cycles sits between
// request accept and response, and access errors are reported.
// Optional build macro DMEM_MISALIGN_ERR_EN: misaligned half/word accesses
// report an error. Without it, the address is aligned down and the access
// proceeds.
module dmem_sized_hs #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject configurations the datapath cannot honour.
  if (DATA_W != 32) begin : g_bad_data_w
    $error("dmem_sized_hs: DATA_W must be 32");
  end
  if (DEPTH < 1 || DEPTH > (1 << (ADDR_W - 2))) begin : g_bad_depth
    $error("dmem_sized_hs: DEPTH must be 1..2^(ADDR_W-2)");
  end
  if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
    $error("dmem_sized_hs: WAIT_CYC must be 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        go_resp;
  req_t        cap, acc;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-3:0] idx;
  logic [IW-1:0]     widx;
  logic [1:0]        lane, lane_eff;
  logic              legal, is_half, is_word, mis, mis_err, oor, err;
  logic [31:0]       rword, ld_data, st_data;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [3:0]        be;

  // The access runs either straight from the bus (IDLE, zero wait cycles)
  // or from the request captured at accept time (WAIT).
  always_comb begin
    acc = (state == S_IDLE) ? '{req_we, req_funct3, req_adr, req_wdata} : cap;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    go_resp    = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYC == 0) begin
            state_nx = S_RESP;
            go_resp  = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = 4'(WAIT_CYC - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESP;
          go_resp  = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Decode size, legality, alignment and range of the current access.
  always_comb begin
    idx     = acc.adr[ADDR_W-1:2];
    lane    = acc.adr[1:0];
    legal   = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    case (acc.funct3)
      3'b000:  legal = 1'b1;
      3'b001:  begin legal = 1'b1; is_half = 1'b1; end
      3'b010:  begin legal = 1'b1; is_word = 1'b1; end
      3'b100:  legal = !acc.we;
      3'b101:  begin legal = !acc.we; is_half = 1'b1; end
      default: legal = 1'b0;
    endcase
    mis = (is_half && lane[0]) || (is_word && (lane != 2'b00));
`ifdef DMEM_MISALIGN_ERR_EN
    mis_err  = mis;
    lane_eff = lane;
`else
    mis_err  = 1'b0;
    lane_eff = is_word ? 2'b00 : (is_half ? {lane[1], 1'b0} : lane);
`endif
    oor  = int'(idx) >= DEPTH;
    err  = !legal || oor || mis_err;
    widx = idx[IW-1:0];
  end

  // Load extraction/extension and store lane placement.
  always_comb begin
    rword   = mem[widx];
    bsel    = rword[{lane_eff, 3'b000} +: 8];
    hsel    = rword[{lane_eff[1], 4'b0000} +: 16];
    ld_data = '0;
    st_data = acc.wdata;
    be      = 4'b0000;
    case (acc.funct3)
      3'b000: begin
        ld_data = {{24{bsel[7]}}, bsel};
        st_data = {4{acc.wdata[7:0]}};
        be      = 4'b0001 << lane_eff;
      end
      3'b001: begin
        ld_data = {{16{hsel[15]}}, hsel};
        st_data = {2{acc.wdata[15:0]}};
        be      = lane_eff[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        ld_data = rword;
        be      = 4'b1111;
      end
      3'b100:  ld_data = {24'h0, bsel};
      3'b101:  ld_data = {16'h0, hsel};
      default: ld_data = '0;
    endcase
  end

  // Store commit on the edge entering RESP; reset on that edge blocks it.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && acc.we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // Request capture and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) cap <= acc;
      if (go_resp) begin
        resp_err   <= err;
        resp_rdata <= (acc.we || err) ? '0 : ld_data;
      end
    end
  end

endmodule
